aes_output_arbiter: RTL
=======================

// Module: aes_output_arbiter
// PURPOSE
//   Collects 128-bit results from NUM_SRC AES datapaths (e.g. 0=decrypt PT, 1=encrypt CT).
//   Selects one result per cycle, by fixed select or by round-robin.
//   Buffers the selected results in a DEPTH-entry FIFO, each tagged with its source id.
//   Presents them on a valid/ready output port; sits between the AES cores and the host/UART interface.
// PARAMETERS
//   DATA_W   128  width of one result word
//   NUM_SRC  2    number of result sources (>=2)
//   DEPTH    4    FIFO entries (power of two, >=2)
//   SRC_W    derived localparam = clog2(NUM_SRC), width of source tag
//   CNT_W    derived localparam = clog2(DEPTH+1), width of occupancy count
// PORTS
//   Clk        in   1                 rising-edge clock
//   Rst        in   1                 asynchronous reset, active-low
//   Mode       in   1                 0 = FIXED (use Sel), 1 = ROUND-ROBIN
//   Sel        in   SRC_W             source index in FIXED mode
//   Flush      in   1                 synchronous clear of FIFO and RR pointer
//   In_Valid   in   NUM_SRC           per-source result valid
//   In_Data    in   NUM_SRC*DATA_W    source i at bits [i*DATA_W +: DATA_W]
//   In_Ready   out  NUM_SRC           one-hot (or zero) grant; a transfer occurs on In_Valid[i] & In_Ready[i]
//   Out_Valid  out  1                 FIFO head valid
//   Out_Ready  in   1                 consumer accepts head
//   Out_Data   out  DATA_W            head result
//   Out_Src    out  SRC_W             head source tag
//   Count      out  CNT_W             FIFO occupancy
//   Ry         out  1                 registered; 1 while Count != 0
// BEHAVIOUR
//   Reset (Rst=0, async): FIFO empty; Count=0, Out_Valid=0, Out_Data=0, Out_Src=0, Ry=0, rr_ptr=0.
//     While in reset, In_Ready=0.
//   space = (Count < DEPTH) | (Out_Valid & Out_Ready); full-FIFO push in the same cycle as a pop is allowed.
//   Grant (combinational, at most one bit set, zero if !space or Flush):
//     FIXED: In_Ready[Sel] = In_Valid[Sel]; Sel >= NUM_SRC -> no grant.
//     RR: first i with In_Valid[i], searching from rr_ptr upward, wrapping mod NUM_SRC.
//     RR: after an accept from source g, rr_ptr <= (g+1) mod NUM_SRC.
//     rr_ptr is held in FIXED mode; Mode/Sel changes take effect in the same cycle.
//   Push writes {g, In_Data[g]} at tail; pop on Out_Valid & Out_Ready advances head.
//   Count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   Latency: accept at edge k into an empty FIFO -> Out_Valid=1 and data visible after edge k.
//     Output ordering is strict FIFO.
//   Out_Data/Out_Src hold stable while Out_Valid & !Out_Ready.
//     When Out_Valid=0 they hold their last value (0 after reset).
//   Pointers wrap mod DEPTH; no overflow is possible (grant gated by space).
//     Pop on empty is ignored.
//   Flush=1: head/tail/Count/rr_ptr <= 0 at the next edge; no push that cycle; pop ignored; Ry<=0.
//   Async reset mid-transfer discards all FIFO content; no partial word is ever emitted.
// STRUCTURE
//   aes_defs.vh: localparams MODE_FIXED=1'b0, MODE_RR=1'b1, SRC_DEC=0, SRC_ENC=1.
//   Sub-module aes_out_fifo (DATA_W+SRC_W wide, DEPTH deep, push/pop/flush, count).
//   Top level: grant logic + rr_ptr register + aes_out_fifo instance.
// TESTING
//   1. Reset then idle -> Out_Valid=0, Count=0, Ry=0, In_Ready=0.
//      Release Rst -> In_Ready follows grant rules.
//   2. FIXED, Sel=1, both valid, Data0=128'h11.., Data1=128'hAA.. -> only In_Ready[1]=1.
//      Out_Data=128'hAA.., Out_Src=1, one cycle later.
//   3. RR, both valid continuously, Out_Ready=1 -> Out_Src alternates 0,1,0,1.
//      One word per cycle, no gaps.
//   4. Out_Ready=0, 6 pushes with DEPTH=4 -> Count saturates at 4, In_Ready=0.
//      Then Out_Ready=1 -> 4 words out in order, then grants resume.
//   5. Full FIFO with simultaneous push and pop -> Count stays 4.
//      New word appears after the 3 older words.
//   6. Flush with Count=3 -> Count=0, Out_Valid=0, rr_ptr=0 next cycle.
//      Drop Rst mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/aes_output_arbiter_pkg.sv
// ============================================================================
// Module : aes_output_arbiter_pkg
// Brief  : Shared mode/source constants and index helper for the AES output arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_output_arbiter_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int SRC_DEC = 0;
    localparam int SRC_ENC = 1;

    // Single-step modulo wrap; callers only ever exceed the modulus by less than one period.
    function automatic int wrap_idx(input int idx, input int modulus);
        return (idx >= modulus) ? idx - modulus : idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_out_fifo.sv
// ============================================================================
// Module : aes_out_fifo
// Brief  : Tagged result FIFO with push/pop/flush, occupancy count and held head output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_out_fifo #(
    parameter  int WIDTH = 129,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             nonempty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [WIDTH-1:0] last_data;
    logic [CNT_W-1:0] count_next;
    logic             do_pop;
    logic             do_push;

    assign head_valid = (count != '0);
    assign do_pop     = pop & head_valid & ~flush;
    assign do_push    = push & ~flush & ((count < CNT_W'(DEPTH)) | do_pop);

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            nonempty <= 1'b0;
        end else begin
            count    <= count_next;
            nonempty <= (count_next != '0);
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (do_push) begin
                    tail <= tail + PTR_W'(1);
                end
                if (do_pop) begin
                    head <= head + PTR_W'(1);
                end
            end
        end
    end

    // Tracks the word currently on the output so it stays visible once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data <= '0;
        end else if (head_valid) begin
            last_data <= mem[head];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    assign head_data = head_valid ? mem[head] : last_data;

endmodule

`default_nettype wire

// File: rtl/aes_output_arbiter.sv
// ============================================================================
// Module : aes_output_arbiter
// Brief  : Fixed/round-robin selection of AES results into a tagged output FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_output_arbiter
    import aes_output_arbiter_pkg::*;
#(
    parameter  int DATA_W  = 128,
    parameter  int NUM_SRC = 2,
    parameter  int DEPTH   = 4,
    localparam int SRC_W   = $clog2(NUM_SRC),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Mode,
    input  logic [SRC_W-1:0]          Sel,
    input  logic                      Flush,
    input  logic [NUM_SRC-1:0]        In_Valid,
    input  logic [NUM_SRC*DATA_W-1:0] In_Data,
    output logic [NUM_SRC-1:0]        In_Ready,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic [DATA_W-1:0]         Out_Data,
    output logic [SRC_W-1:0]          Out_Src,
    output logic [CNT_W-1:0]          Count,
    output logic                      Ry
);

    logic [SRC_W-1:0]        rr_ptr;
    logic [NUM_SRC-1:0]      grant;
    logic [SRC_W-1:0]        grant_idx;
    logic                    grant_any;
    logic [DATA_W-1:0]       grant_data;
    logic                    space;
    logic [SRC_W+DATA_W-1:0] head_word;
    int                      cand;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign space = (Count < CNT_W'(DEPTH)) | (Out_Valid & Out_Ready);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        if (Rst && space && !Flush) begin
            if (Mode == MODE_FIXED) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (Sel == SRC_W'(i) && In_Valid[i]) begin
                        grant[i]  = 1'b1;
                        grant_idx = SRC_W'(i);
                        grant_any = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    cand = wrap_idx(int'(rr_ptr) + k, NUM_SRC);
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (!grant_any && i == cand && In_Valid[i]) begin
                            grant[i]  = 1'b1;
                            grant_idx = SRC_W'(i);
                            grant_any = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                grant_data = In_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign In_Ready = grant;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rr_ptr <= '0;
        end else if (Flush) begin
            rr_ptr <= '0;
        end else if (grant_any && Mode == MODE_RR) begin
            if (int'(grant_idx) == NUM_SRC - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + SRC_W'(1);
            end
        end
    end

    aes_out_fifo #(
        .WIDTH (SRC_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (Clk),
        .rst_n      (Rst),
        .push       (grant_any),
        .push_data  ({grant_idx, grant_data}),
        .pop        (Out_Ready),
        .flush      (Flush),
        .head_valid (Out_Valid),
        .head_data  (head_word),
        .count      (Count),
        .nonempty   (Ry)
    );

    assign Out_Data = head_word[DATA_W-1:0];
    assign Out_Src  = head_word[SRC_W+DATA_W-1:DATA_W];

endmodule

`default_nettype wire
